// File: rtl/seg_scan_rx.sv
// rtl/seg_scan_rx.sv - decodes a low-active 7-segment scan stream back into a BCD time word
// Optional macro SEGRX_DP_EN: capture, compare and publish per-digit decimal points on DP.
module seg_scan_rx #(
  parameter int SETTLE       = 4,
  parameter int MATCH_FRAMES = 2,
  parameter int TO_W         = 20
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  SEGN,
  input  logic [7:0]  AN,
  output logic [31:0] TIME,
  output logic        VALID,
  output logic        ERR,
  output logic [7:0]  DP
);

  localparam int SW = (SETTLE > 2) ? $clog2(SETTLE) : 1;
  localparam int MW = (MATCH_FRAMES > 2) ? $clog2(MATCH_FRAMES) : 1;

  typedef enum logic {SYNC, COLLECT} state_t;
  state_t state, state_next;

  logic [7:0]      seg, en, seg_prev, en_prev;
  logic [SW-1:0]   settle_cnt;
  logic [7:0]      mask, mask_new;
  logic [31:0]     shadow, frame, last_frame;
  logic            last_vld;
  logic [MW-1:0]   match, match_next;
  logic [TO_W-1:0] to_cnt;
  logic            publish;
  logic            stable, capture, dec_ok, good, bad, complete, timeout, same;
  logic [3:0]      dec_nib;
  logic [2:0]      idx;

  assign stable  = (seg == seg_prev) && (en == en_prev);
  assign capture = stable && (settle_cnt == SW'(SETTLE - 2));

  always_comb begin
    dec_ok  = 1'b1;
    dec_nib = 4'd0;
    case (seg[6:0])
      7'h3F: dec_nib = 4'd0;
      7'h06: dec_nib = 4'd1;
      7'h5B: dec_nib = 4'd2;
      7'h4F: dec_nib = 4'd3;
      7'h66: dec_nib = 4'd4;
      7'h6D: dec_nib = 4'd5;
      7'h7D: dec_nib = 4'd6;
      7'h07: dec_nib = 4'd7;
      7'h7F: dec_nib = 4'd8;
      7'h6F: dec_nib = 4'd9;
      default: dec_ok = 1'b0;
    endcase
  end

  always_comb begin
    idx = 3'd0;
    for (int i = 0; i < 8; i++)
      if (en[i]) idx = 3'(i);
  end

  always_comb begin
    frame = shadow;
    frame[{idx, 2'b00} +: 4] = dec_nib;
    mask_new = mask | (8'h01 << idx);
  end

  // A blank (no digit enabled) is a legal inter-digit gap and is ignored silently.
  assign good     = capture && $onehot(en) && dec_ok;
  assign bad      = capture && (en != 8'h00) && !($onehot(en) && dec_ok);
  assign complete = good && (mask_new == 8'hFF);
  assign timeout  = !complete && (&to_cnt);

  always_comb begin
    match_next = '0;
    if (same)
      match_next = (match == MW'(MATCH_FRAMES - 1)) ? match : match + 1'b1;
  end

`ifdef SEGRX_DP_EN
  logic [7:0] dp_shadow, dp_frame, last_dp;

  always_comb begin
    dp_frame      = dp_shadow;
    dp_frame[idx] = seg[7];
  end

  assign same = last_vld && (frame == last_frame) && (dp_frame == last_dp);

  always_ff @(posedge CLK) begin
    if (RST) begin
      dp_shadow <= 8'h00;
      last_dp   <= 8'h00;
      DP        <= 8'h00;
    end else begin
      if (good) dp_shadow <= dp_frame;
      if (complete) last_dp <= dp_frame;
      if (publish) DP <= last_dp;
    end
  end
`else
  assign same = last_vld && (frame == last_frame);
  assign DP   = 8'h00;
`endif

  always_ff @(posedge CLK) begin
    if (RST) state <= SYNC;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      SYNC:    if (good && !timeout) state_next = COLLECT;
      COLLECT: if (complete || bad || timeout) state_next = SYNC;
      default: state_next = SYNC;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      seg        <= 8'h00;
      en         <= 8'h00;
      seg_prev   <= 8'h00;
      en_prev    <= 8'h00;
      settle_cnt <= '0;
      mask       <= 8'h00;
      shadow     <= 32'h0;
      last_frame <= 32'h0;
      last_vld   <= 1'b0;
      match      <= '0;
      to_cnt     <= '0;
      publish    <= 1'b0;
      TIME       <= 32'h0;
      VALID      <= 1'b0;
      ERR        <= 1'b0;
    end else begin
      seg      <= ~SEGN;
      en       <= ~AN;
      seg_prev <= seg;
      en_prev  <= en;
      if (!stable)
        settle_cnt <= '0;
      else if (settle_cnt != SW'(SETTLE - 1))
        settle_cnt <= settle_cnt + 1'b1;

      to_cnt  <= complete ? '0 : to_cnt + 1'b1;
      publish <= complete && (match_next == MW'(MATCH_FRAMES - 1));
      if (publish) begin
        TIME  <= last_frame;
        VALID <= 1'b1;
      end

      if (bad) begin
        ERR   <= 1'b1;
        mask  <= 8'h00;
        match <= '0;
      end else if (good) begin
        shadow <= frame;
        if (complete) begin
          mask       <= 8'h00;
          last_frame <= frame;
          last_vld   <= 1'b1;
          match      <= match_next;
        end else begin
          mask <= mask_new;
        end
      end

      // Timeout wins over a concurrent partial capture so the next frame starts clean.
      if (timeout) begin
        VALID <= 1'b0;
        match <= '0;
        mask  <= 8'h00;
      end
    end
  end

endmodule
